// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the memory access stage: FSM state encodings,
// default datapath width, default access timeout and timeout counter width.
package mem_access_stage_pkg;

  localparam int DEFAULT_DATA_W  = 16;
  localparam int DEFAULT_TIMEOUT = 255;
  localparam int CTR_W           = 16;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/mem_access_stage_timeout_ctr.sv
// mem_timeout_ctr: counts consecutive BUSY cycles of an outstanding memory
// access and flags the last cycle the stage is willing to wait.
// expire_o is high during the TIMEOUT-th enabled cycle since the last clear.
module mem_timeout_ctr
  import mem_access_stage_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam logic [CTR_W-1:0] LAST = CTR_W'(TIMEOUT - 1);

  logic [CTR_W-1:0] count_q;
  logic [CTR_W-1:0] count_d;

  // Clear has priority so a finished or abandoned access starts the next one at zero
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register, zeroed by reset so an abandoned access leaves no residue
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_o = enable_i & (count_q == LAST);

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: memory stage between execute and writeback.
// Non-memory instructions complete one cycle after acceptance. Loads and
// stores issue a registered request and wait in BUSY for mem_done, stalling
// upstream meanwhile; an access that never completes is abandoned after
// TIMEOUT BUSY cycles and flagged through the sticky err output.
// Optional build macro MEM_ALIGN_CHK_EN: when defined, a memory op whose
// address has bit 0 set is rejected without a request; otherwise the
// address is forwarded unchanged.
// stall_req has a combinational path from mem_done while BUSY so upstream
// can advance on the same edge the access completes.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] aluResult,
  input  logic [DATA_W-1:0] storeData,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic              regWrite,
  input  logic [2:0]        wbReg,
  output logic              stall_req,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_done,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_regWrite,
  output logic [2:0]        out_wbReg,
  output logic              err
);

  state_e            state_q;
  logic [DATA_W-1:0] memAddr_q;
  logic [DATA_W-1:0] memWdata_q;
  logic              memRd_q;
  logic              memWr_q;
  logic              regWrite_q;
  logic [2:0]        wbReg_q;
  logic              outValid_q;
  logic [DATA_W-1:0] outData_q;
  logic              outRegWrite_q;
  logic [2:0]        outWbReg_q;
  logic              err_q;

  logic busy;
  logic memop;
  logic illegalOp;
  logic misaligned;
  logic reqOk;
  logic rejectOp;
  logic expire;
  logic ctrClear;

  assign busy      = (state_q == BUSY);
  assign memop     = in_valid & (memRead | memWrite);
  assign illegalOp = memRead & memWrite;

`ifdef MEM_ALIGN_CHK_EN
  assign misaligned = aluResult[0];
`else
  assign misaligned = 1'b0;
`endif

  assign reqOk    = memop & ~illegalOp & ~misaligned;
  assign rejectOp = memop & ~reqOk;

  // The counter only runs while an access is outstanding and restarts once it ends
  assign ctrClear = ~busy | mem_done | expire;

  mem_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (ctrClear),
    .enable_i (busy),
    .expire_o (expire)
  );

  // Hold upstream while accepting a request or waiting; release on done or abandon
  assign stall_req = ~rst & (busy ? (~mem_done & ~expire) : reqOk);

  // Stage FSM with registered request, latched instruction info and writeback outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      memAddr_q     <= '0;
      memWdata_q    <= '0;
      memRd_q       <= 1'b0;
      memWr_q       <= 1'b0;
      regWrite_q    <= 1'b0;
      wbReg_q       <= '0;
      outValid_q    <= 1'b0;
      outData_q     <= '0;
      outRegWrite_q <= 1'b0;
      outWbReg_q    <= '0;
      err_q         <= 1'b0;
    end else begin
      outValid_q    <= 1'b0;
      outRegWrite_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (reqOk) begin
            state_q    <= BUSY;
            memAddr_q  <= aluResult;
            memWdata_q <= storeData;
            memRd_q    <= memRead;
            memWr_q    <= memWrite;
            regWrite_q <= regWrite;
            wbReg_q    <= wbReg;
          end else if (rejectOp) begin
            outValid_q <= 1'b1;
            outData_q  <= '0;
            outWbReg_q <= wbReg;
            err_q      <= 1'b1;
          end else if (in_valid) begin
            outValid_q    <= 1'b1;
            outData_q     <= aluResult;
            outRegWrite_q <= regWrite;
            outWbReg_q    <= wbReg;
          end
        end
        BUSY: begin
          if (mem_done) begin
            state_q       <= IDLE;
            memRd_q       <= 1'b0;
            memWr_q       <= 1'b0;
            outValid_q    <= 1'b1;
            outData_q     <= memRd_q ? mem_rdata : memAddr_q;
            outRegWrite_q <= memRd_q & regWrite_q;
            outWbReg_q    <= wbReg_q;
          end else if (expire) begin
            state_q    <= IDLE;
            memRd_q    <= 1'b0;
            memWr_q    <= 1'b0;
            outValid_q <= 1'b1;
            outData_q  <= '0;
            outWbReg_q <= wbReg_q;
            err_q      <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_addr     = memAddr_q;
  assign mem_wdata    = memWdata_q;
  assign mem_rd       = memRd_q;
  assign mem_wr       = memWr_q;
  assign out_valid    = outValid_q;
  assign out_data     = outData_q;
  assign out_regWrite = outRegWrite_q;
  assign out_wbReg    = outWbReg_q;
  assign err          = err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed testbench for mem_access_stage (TIMEOUT=4). Inputs change and
// outputs are sampled 1ns after each rising edge; combinational stall_req
// is sampled a further 1ns after inputs change.
module tb_mem_access_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] aluResult;
  logic [15:0] storeData;
  logic        memRead;
  logic        memWrite;
  logic        regWrite;
  logic [2:0]  wbReg;
  logic        stall_req;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] mem_rdata;
  logic        mem_done;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_regWrite;
  logic [2:0]  out_wbReg;
  logic        err;

  int assertCount = 0;
  int failCount   = 0;
  int stallCount  = 0;

  mem_access_stage #(
    .DATA_W  (16),
    .TIMEOUT (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .aluResult    (aluResult),
    .storeData    (storeData),
    .memRead      (memRead),
    .memWrite     (memWrite),
    .regWrite     (regWrite),
    .wbReg        (wbReg),
    .stall_req    (stall_req),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rd       (mem_rd),
    .mem_wr       (mem_wr),
    .mem_rdata    (mem_rdata),
    .mem_done     (mem_done),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_regWrite (out_regWrite),
    .out_wbReg    (out_wbReg),
    .err          (err)
  );

  // Free-running 10ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value against its hand-computed expectation
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive the execute-stage side of the interface
  task automatic applyStimulus(input logic v, input logic [15:0] alu, input logic [15:0] sd,
                               input logic rd, input logic wr, input logic rw, input logic [2:0] wb);
    in_valid  = v;
    aluResult = alu;
    storeData = sd;
    memRead   = rd;
    memWrite  = wr;
    regWrite  = rw;
    wbReg     = wb;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd0);
  endtask

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Directed sequence
  initial begin
    rst       = 1'b1;
    mem_done  = 1'b0;
    mem_rdata = 16'h0000;
    idleInputs();
    nextCycle();
    nextCycle();

    // Reset state
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_mem_rd",    32'(mem_rd),    32'd0);
    checkOutput("rst_err",       32'(err),       32'd0);
    checkOutput("rst_out_data",  32'(out_data),  32'h0);
    checkOutput("rst_stall",     32'(stall_req), 32'd0);
    rst = 1'b0;

    // Non-memory op: one-cycle pass-through, never stalls
    applyStimulus(1'b1, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b1, 3'd3);
    #1;
    checkOutput("alu_stall", 32'(stall_req), 32'd0);
    nextCycle();
    idleInputs();
    checkOutput("alu_valid",    32'(out_valid),    32'd1);
    checkOutput("alu_data",     32'(out_data),     32'h1234);
    checkOutput("alu_wbreg",    32'(out_wbReg),    32'd3);
    checkOutput("alu_regwrite", 32'(out_regWrite), 32'd1);
    checkOutput("alu_stall2",   32'(stall_req),    32'd0);
    nextCycle();
    checkOutput("alu_pulse", 32'(out_valid), 32'd0);

    // Load at 0x0040, done in the 4th BUSY cycle (coincides with the last timeout cycle)
    stallCount = 0;
    applyStimulus(1'b1, 16'h0040, 16'h0000, 1'b1, 1'b0, 1'b1, 3'd5);
    #1;
    if (stall_req) stallCount++;
    checkOutput("ld_accept_stall", 32'(stall_req), 32'd1);
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      if (stall_req) stallCount++;
      checkOutput("ld_busy_rd",    32'(mem_rd),    32'd1);
      checkOutput("ld_busy_stall", 32'(stall_req), 32'd1);
    end
    checkOutput("ld_addr",     32'(mem_addr),  32'h0040);
    checkOutput("ld_no_valid", 32'(out_valid), 32'd0);
    nextCycle();
    mem_done  = 1'b1;
    mem_rdata = 16'hBEEF;
    #1;
    if (stall_req) stallCount++;
    checkOutput("ld_done_stall", 32'(stall_req), 32'd0);
    checkOutput("ld_stall_count", 32'(stallCount), 32'd4);
    nextCycle();
    mem_done = 1'b0;
    idleInputs();
    checkOutput("ld_valid",    32'(out_valid),    32'd1);
    checkOutput("ld_data",     32'(out_data),     32'hBEEF);
    checkOutput("ld_regwrite", 32'(out_regWrite), 32'd1);
    checkOutput("ld_wbreg",    32'(out_wbReg),    32'd5);
    checkOutput("ld_rd_drop",  32'(mem_rd),       32'd0);
    checkOutput("ld_no_err",   32'(err),          32'd0);
    nextCycle();

    // Store 0xA5A5 to 0x0010, done after one BUSY cycle, then back-to-back ALU op
    applyStimulus(1'b1, 16'h0010, 16'hA5A5, 1'b0, 1'b1, 1'b1, 3'd2);
    #1;
    checkOutput("st_accept_stall", 32'(stall_req), 32'd1);
    nextCycle();
    checkOutput("st_wr",    32'(mem_wr),    32'd1);
    checkOutput("st_rd",    32'(mem_rd),    32'd0);
    checkOutput("st_wdata", 32'(mem_wdata), 32'hA5A5);
    checkOutput("st_addr",  32'(mem_addr),  32'h0010);
    mem_done = 1'b1;
    #1;
    checkOutput("st_done_stall", 32'(stall_req), 32'd0);
    nextCycle();
    mem_done = 1'b0;
    applyStimulus(1'b1, 16'h5555, 16'h0000, 1'b0, 1'b0, 1'b1, 3'd6);
    checkOutput("st_valid",    32'(out_valid),    32'd1);
    checkOutput("st_data",     32'(out_data),     32'h0010);
    checkOutput("st_regwrite", 32'(out_regWrite), 32'd0);
    checkOutput("st_wr_drop",  32'(mem_wr),       32'd0);
    nextCycle();
    idleInputs();
    checkOutput("b2b_valid", 32'(out_valid), 32'd1);
    checkOutput("b2b_data",  32'(out_data),  32'h5555);
    checkOutput("b2b_wbreg", 32'(out_wbReg), 32'd6);
    nextCycle();

    // Load that never completes: abandoned after 4 BUSY cycles
    applyStimulus(1'b1, 16'h0080, 16'h0000, 1'b1, 1'b0, 1'b1, 3'd1);
    for (int i = 0; i < 4; i++) begin
      nextCycle();
      checkOutput("to_busy_stall", 32'(stall_req), (i < 3) ? 32'd1 : 32'd0);
    end
    nextCycle();
    idleInputs();
    checkOutput("to_rd_drop",  32'(mem_rd),       32'd0);
    checkOutput("to_err",      32'(err),          32'd1);
    checkOutput("to_valid",    32'(out_valid),    32'd1);
    checkOutput("to_data",     32'(out_data),     32'h0);
    checkOutput("to_regwrite", 32'(out_regWrite), 32'd0);
    nextCycle();
    checkOutput("to_err_sticky", 32'(err),       32'd1);
    checkOutput("to_pulse",      32'(out_valid), 32'd0);

    // Reset pulsed mid-BUSY, then a clean load
    applyStimulus(1'b1, 16'h0020, 16'h0000, 1'b1, 1'b0, 1'b1, 3'd4);
    nextCycle();
    nextCycle();
    checkOutput("mid_rd_before", 32'(mem_rd), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("mid_rd",    32'(mem_rd),    32'd0);
    checkOutput("mid_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_stall", 32'(stall_req), 32'd0);
    checkOutput("mid_err",   32'(err),       32'd0);
    idleInputs();
    #2;
    rst = 1'b0;
    nextCycle();
    applyStimulus(1'b1, 16'h0030, 16'h0000, 1'b1, 1'b0, 1'b1, 3'd7);
    nextCycle();
    mem_done  = 1'b1;
    mem_rdata = 16'h1357;
    nextCycle();
    mem_done = 1'b0;
    idleInputs();
    checkOutput("post_valid", 32'(out_valid), 32'd1);
    checkOutput("post_data",  32'(out_data),  32'h1357);
    checkOutput("post_wbreg", 32'(out_wbReg), 32'd7);
    checkOutput("post_err",   32'(err),       32'd0);
    nextCycle();

    // Odd address load
    applyStimulus(1'b1, 16'h0041, 16'h0000, 1'b1, 1'b0, 1'b1, 3'd2);
`ifdef MEM_ALIGN_CHK_EN
    #1;
    checkOutput("mis_stall", 32'(stall_req), 32'd0);
    nextCycle();
    idleInputs();
    checkOutput("mis_rd",       32'(mem_rd),       32'd0);
    checkOutput("mis_err",      32'(err),          32'd1);
    checkOutput("mis_valid",    32'(out_valid),    32'd1);
    checkOutput("mis_data",     32'(out_data),     32'h0);
    checkOutput("mis_regwrite", 32'(out_regWrite), 32'd0);
`else
    nextCycle();
    checkOutput("odd_addr", 32'(mem_addr), 32'h0041);
    checkOutput("odd_rd",   32'(mem_rd),   32'd1);
    mem_done  = 1'b1;
    mem_rdata = 16'h2468;
    nextCycle();
    mem_done = 1'b0;
    idleInputs();
    checkOutput("odd_data", 32'(out_data), 32'h2468);
    checkOutput("odd_err",  32'(err),      32'd0);
`endif
    nextCycle();

    // Illegal read+write: no request, immediate error response
    applyStimulus(1'b1, 16'h0050, 16'h1111, 1'b1, 1'b1, 1'b1, 3'd4);
    #1;
    checkOutput("ill_stall", 32'(stall_req), 32'd0);
    nextCycle();
    idleInputs();
    checkOutput("ill_rd",       32'(mem_rd),       32'd0);
    checkOutput("ill_wr",       32'(mem_wr),       32'd0);
    checkOutput("ill_valid",    32'(out_valid),    32'd1);
    checkOutput("ill_regwrite", 32'(out_regWrite), 32'd0);
    checkOutput("ill_err",      32'(err),          32'd1);
    nextCycle();
    checkOutput("ill_pulse", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
